// File: rtl/pipeline_store_buffer.sv
// Store buffer between the MEM stage and the data memory. Stores are queued and
// retired in program order when the write port is free; loads forward from the youngest match.
module pipeline_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Empty,
  input  logic        Mem_Busy,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_MemRd,
  output logic        Mem_MemWr,
  input  logic [31:0] Mem_ReadData
);

  localparam int PW = $clog2(DEPTH);

  logic [29:0]   entry_addr [DEPTH];
  logic [31:0]   entry_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          full;
  logic          drain;
  logic          enq;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign Empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  // Loads own the memory port, so a drain only happens in a non-load cycle.
  assign drain = !Empty && !MemRd && !Mem_Busy;
  assign Stall = MemWr && full && !drain;
  assign enq   = MemWr && !Stall;

  assign Mem_MemRd     = MemRd;
  assign Mem_MemWr     = drain;
  assign Mem_Addr      = MemRd ? Addr : {entry_addr[head], 2'b00};
  assign Mem_WriteData = entry_data[head];

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entry_addr[idx] == Addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[idx];
      end
    end
  end

  assign ReadData = MemRd ? (fwd_hit ? fwd_data : Mem_ReadData) : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (enq)   tail <= tail + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry contents are left alone by reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr[tail] <= Addr[31:2];
      entry_data[tail] <= WriteData;
    end
  end

endmodule

// File: tb/tb_pipeline_store_buffer.sv
// Self-checking bench for pipeline_store_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model and a reference memory image.
module tb_pipeline_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd, MemWr, Mem_Busy;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Empty;
  logic [31:0] Mem_Addr, Mem_WriteData, Mem_ReadData;
  logic        Mem_MemRd, Mem_MemWr;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  pipeline_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Empty(Empty),
    .Mem_Busy(Mem_Busy), .Mem_Addr(Mem_Addr), .Mem_WriteData(Mem_WriteData),
    .Mem_MemRd(Mem_MemRd), .Mem_MemWr(Mem_MemWr), .Mem_ReadData(Mem_ReadData)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign Mem_ReadData = mem[Mem_Addr[7:2]];
  always @(posedge clk) if (Mem_MemWr) mem[Mem_Addr[7:2]] <= Mem_WriteData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic busy);
    logic        e_drain, e_stall, hit;
    logic [31:0] e_rdata;
    MemRd = rd; MemWr = wr; Addr = a; WriteData = d; Mem_Busy = busy;
    #1;
    e_drain = (q_addr.size() != 0) && !rd && !busy;
    e_stall = wr && (q_addr.size() == DEPTH) && !e_drain;
    checkOutput("stall", {31'b0, Stall}, {31'b0, e_stall});
    checkOutput("empty", {31'b0, Empty}, {31'b0, q_addr.size() == 0});
    checkOutput("mem_wr", {31'b0, Mem_MemWr}, {31'b0, e_drain});
    checkOutput("mem_rd", {31'b0, Mem_MemRd}, {31'b0, rd});
    if (e_drain) begin
      checkOutput("drain_addr", Mem_Addr, {q_addr[0][31:2], 2'b00});
      checkOutput("drain_data", Mem_WriteData, q_data[0]);
    end
    if (rd) begin
      hit = 1'b0;
      e_rdata = ref_mem[a[7:2]];
      for (int i = q_addr.size() - 1; i >= 0; i--)
        if (!hit && q_addr[i][31:2] == a[31:2]) begin
          hit = 1'b1;
          e_rdata = q_data[i];
        end
      checkOutput("load_addr", Mem_Addr, a);
      checkOutput("load_data", ReadData, e_rdata);
    end else begin
      checkOutput("idle_rdata", ReadData, 32'h0);
    end
    @(posedge clk);
    if (e_drain) begin
      ref_mem[q_addr[0][7:2]] = q_data[0];
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (wr && !e_stall) begin
      q_addr.push_back(a);
      q_data.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic midReset();
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b1; Mem_Busy = 1'b1;
    #1;
    checkOutput("rst_empty", {31'b0, Empty}, 32'h1);
    checkOutput("rst_stall", {31'b0, Stall}, 32'h0);
    checkOutput("rst_memwr", {31'b0, Mem_MemWr}, 32'h0);
    checkOutput("rst_rdata", ReadData, 32'h0);
    q_addr.delete();
    q_data.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic        rd, wr, busy, held;
    logic [31:0] a, d;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    MemRd = 0; MemWr = 0; Addr = 0; WriteData = 0; Mem_Busy = 0;
    reset = 1'b1;
    #1;
    checkOutput("reset_empty", {31'b0, Empty}, 32'h1);
    checkOutput("reset_stall", {31'b0, Stall}, 32'h0);
    checkOutput("reset_memwr", {31'b0, Mem_MemWr}, 32'h0);
    checkOutput("reset_rdata", ReadData, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single store drains on the next idle cycle.
    applyStimulus(0, 1, 32'h10, 32'h11111111, 0);
    idle(2);
    checkOutput("mem_word4", mem[4], 32'h11111111);

    // Forwarding from the youngest duplicate, byte bits ignored.
    applyStimulus(0, 1, 32'h20, 32'hAAAA0001, 1);
    applyStimulus(0, 1, 32'h20, 32'hBBBB0002, 1);
    applyStimulus(1, 0, 32'h22, 32'h0, 1);
    applyStimulus(1, 0, 32'h24, 32'h0, 1);
    idle(3);
    checkOutput("mem_word8", mem[8], 32'hBBBB0002);

    // Fill while busy, stall the fifth, then drain and enqueue on the same edge.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h40 + 4 * i, 32'hC0 + i, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h50, 32'hC4, 1);
    applyStimulus(0, 1, 32'h50, 32'hC4, 0);
    applyStimulus(0, 1, 32'h54, 32'hC5, 1);

    // Full buffer, alternating load/store with a free port; wraps the pointers.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 32'h40 + 4 * (i % 6), 32'h0, 0);
      applyStimulus(0, 1, 32'h58 + 4 * i, 32'hD0 + i, 0);
    end
    idle(6);

    // Reset with stores pending: they must never reach memory.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h80 + 4 * i, 32'hE0 + i, 1);
    midReset();
    idle(4);
    applyStimulus(1, 0, 32'h84, 32'h0, 0);

    // Back-to-back loads block draining until the first non-load cycle.
    applyStimulus(0, 1, 32'h90, 32'hF0, 1);
    applyStimulus(0, 1, 32'h94, 32'hF1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'h90 + 4 * (i % 3), 32'h0, 0);
    idle(3);

    // Random traffic over a small address window; stalled stores are re-presented.
    held = 1'b0; a = 0; d = 0;
    for (int i = 0; i < 500; i++) begin
      busy = ($urandom_range(0, 3) == 0);
      if (held) begin
        rd = 1'b0; wr = 1'b1;
      end else begin
        case ($urandom_range(0, 2))
          0: begin rd = 1'b1; wr = 1'b0; end
          1: begin rd = 1'b0; wr = 1'b1; end
          default: begin rd = 1'b0; wr = 1'b0; end
        endcase
        a = {24'h0, 2'b00, 4'($urandom_range(0, 7)), 2'($urandom)};
        d = $urandom;
      end
      held = wr && (q_addr.size() == DEPTH) && !(!busy && q_addr.size() != 0);
      applyStimulus(rd, wr, a, d, busy);
    end
    idle(DEPTH + 2);

    for (int i = 0; i < 64; i++) checkOutput("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
